alu_exec_unit: RTL
==================

// Module: alu_exec_unit
// PURPOSE
//  Execute-stage consumer of the 4-bit ALU operation code from the ALU control decoder.
//  Takes operands A/B plus the op code through a valid/ready handshake and returns a registered result.
//  Also returns a zero flag and a branch-taken flag.
//  SLL/SRL run on an iterative one-bit-per-cycle shifter; in_ready_o stalls the pipeline while a shift runs.
// PARAMETERS
//  DATA_WIDTH   32   operand/result width
//  SHAMT_WIDTH  5    shift amount bits taken from B[SHAMT_WIDTH-1:0]
// PORTS
//  clk           in   1           rising-edge clock
//  reset         in   1           synchronous, active-low reset
//  in_valid_i    in   1           op/operands valid
//  in_ready_o    out  1           unit accepts op this cycle
//  alu_op_i      in   4           ALU operation code (see BEHAVIOUR)
//  a_i           in   DATA_WIDTH  operand A (rs1 / PC)
//  b_i           in   DATA_WIDTH  operand B (rs2 / imm)
//  out_valid_o   out  1           result valid
//  out_ready_i   in   1           downstream consumes result
//  result_o      out  DATA_WIDTH  registered result
//  zero_o        out  1           result_o == 0
//  branch_o      out  1           branch condition true (BEQ/BNE only)
// BEHAVIOUR
//  Op codes: 0000 ADD a+b | 0001 SUB a-b | 0010 AND | 0011 OR | 0100 XOR.
//  More op codes: 0101 SLL a<<shamt | 0110 SRL a>>shamt (logical) | 0111 LUI result=b.
//  Branch op codes: 1000 BEQ result=a-b, branch=(a==b) | 1001 BNE result=a-b, branch=(a!=b).
//  Op codes 1010-1111: result 0, branch 0, zero 1; no error signalled.
//  Arithmetic is modulo 2^DATA_WIDTH; carry/overflow discarded. branch_o=0 for non-branch ops.
//  Reset values: out_valid_o=0, result_o=0, zero_o=1, branch_o=0, state=IDLE, in_ready_o=1.
//  Handshake: transfer occurs when valid && ready. out_valid_o stays high and result_o/flags hold until out_ready_i.
//  in_ready_o = (state==IDLE) && (!out_valid_o || out_ready_i); accept and drain may coincide.
//  States: IDLE, SHIFT.
//   IDLE + accept of non-shift op, or shift with shamt==0:
//     result registered at the next edge; out_valid_o=1. Latency 1.
//   IDLE + accept of SLL/SRL with shamt>0: load shifter with a_i, count=shamt, go to SHIFT.
//   SHIFT: shift one bit per cycle and decrement count.
//     On the edge where count reaches 0, result is written, out_valid_o=1, state returns to IDLE.
//     Shift latency is shamt cycles (1..31); in_ready_o=0 throughout.
//   Output register must be empty or draining to enter SHIFT, so a finished shift never overwrites an unconsumed result.
//  Boundaries:
//   shamt uses only B[4:0]; upper bits ignored.
//   in_valid_i while busy is ignored; the source must hold its inputs.
//   out_ready_i low indefinitely: result holds and in_ready_o stays 0.
//   Reset low mid-shift: shift abandoned, all outputs return to reset values at that edge.
// CONFIGURATION
//  ALU_EXEC_FAST_SHIFT_EN defined:
//   SLL/SRL use a combinational barrel shifter with latency 1 like other ops.
//   SHIFT state and counter are not built; in_ready_o depends only on the output register.
//  ALU_EXEC_FAST_SHIFT_EN undefined: iterative shifter as described above (default build).
// STRUCTURE
//  alu_exec_pkg: localparams for the 4-bit op codes (shared with the ALU control decoder), state encoding.
//  alu_exec_pkg also holds SHIFT_LEFT/SHIFT_RIGHT direction constants.
//  Sub-module alu_serial_shifter owns the shift register, down-counter and done pulse.
//   It is instantiated only when ALU_EXEC_FAST_SHIFT_EN is undefined.
//  Top level owns the handshake, the op mux and the output register.
// TESTING
//  Reset: reset=0 for 2 cycles -> out_valid_o=0, result_o=0, zero_o=1, branch_o=0, in_ready_o=1.
//  ADD a=0xFFFFFFFF b=1, out_ready_i=1 -> next cycle result_o=0, zero_o=1, out_valid_o=1 for exactly 1 cycle.
//  BEQ a=b=0x1234 -> branch_o=1, zero_o=1.
//  BNE a=5 b=5 -> branch_o=0, result_o=0.
//  SRL a=0x80000000 b=0x23 (shamt=3) -> in_ready_o=0 for 3 cycles, then result_o=0x10000000.
//  Same SRL with fast shift enabled -> result after 1 cycle.
//  Backpressure: out_ready_i=0, issue XOR then SUB -> first result holds and in_ready_o=0.
//   Raise out_ready_i -> XOR drains and SUB is accepted in that same cycle.
//  SLL shamt=31, reset=0 at cycle 10 -> out_valid_o=0, state IDLE.
//   Next ADD 2+3 returns 5 in 1 cycle.

Source files
------------

// File: rtl/alu_exec_pkg.sv
// Shared definitions for the ALU execute unit: op codes, FSM encoding and
// shift direction constants. The op codes are also used by the ALU control
// decoder, so they must stay in step with it.
`timescale 1ns/1ps

package alu_exec_pkg;

  // 4-bit ALU operation codes
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_LUI = 4'b0111;
  localparam logic [3:0] OP_BEQ = 4'b1000;
  localparam logic [3:0] OP_BNE = 4'b1001;

  // Shift direction for the serial shifter
  localparam logic SHIFT_LEFT  = 1'b0;
  localparam logic SHIFT_RIGHT = 1'b1;

  // Execute-unit FSM states (only used by the iterative shifter build)
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/alu_serial_shifter.sv
// Iterative one-bit-per-cycle logical shifter. A start pulse loads the
// operand and shift count; each following cycle shifts once and decrements
// the count. done is high in the cycle whose edge performs the final shift,
// with data_out holding the finished value to capture at that edge.
`timescale 1ns/1ps

module alu_serial_shifter
  import alu_exec_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   dir,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic [SHAMT_WIDTH-1:0] amount,
  output logic                   done,
  output logic [DATA_WIDTH-1:0]  data_out
);

  logic [DATA_WIDTH-1:0]  shift_q;
  logic [SHAMT_WIDTH-1:0] count_q;
  logic                   dir_q;
  logic                   busy;

  assign busy     = (count_q != '0);
  assign done     = (count_q == SHAMT_WIDTH'(1));
  assign data_out = (dir_q == SHIFT_RIGHT) ? (shift_q >> 1) : (shift_q << 1);

  // Load on start, otherwise shift one bit and count down while busy
  always_ff @(posedge clk) begin
    if (!reset) begin
      shift_q <= '0;
      count_q <= '0;
      dir_q   <= SHIFT_LEFT;
    end else if (start) begin
      shift_q <= data_in;
      count_q <= amount;
      dir_q   <= dir;
    end else if (busy) begin
      shift_q <= data_out;
      count_q <= count_q - SHAMT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execute unit: accepts an op code and two operands, returns a
// registered result with zero and branch-taken flags.
// Build option ALU_EXEC_FAST_SHIFT_EN: when defined, SLL/SRL use a
// combinational barrel shifter (latency 1, no SHIFT state); when undefined,
// shifts run on the iterative serial shifter and stall the input.
//
// Handshake: a transfer happens on an edge where valid && ready are both
// high. The input side is ready only when idle and the output register is
// empty or being drained in the same cycle. The output side holds
// out_valid_o, result_o and the flags stable until out_ready_i is seen high.
`timescale 1ns/1ps

module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [3:0]            alu_op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  zero_o,
  output logic                  branch_o
);

  logic                   out_valid_q;
  logic [DATA_WIDTH-1:0]  result_q;
  logic                   zero_q;
  logic                   branch_q;

  logic [SHAMT_WIDTH-1:0] shamt;
  logic                   accept;
  logic                   load_result;
  logic [DATA_WIDTH-1:0]  alu_result;
  logic                   alu_branch;
  logic [DATA_WIDTH-1:0]  next_result;
  logic                   next_branch;
  logic                   out_free;

  assign shamt    = b_i[SHAMT_WIDTH-1:0];
  assign out_free = !out_valid_q || out_ready_i;
  assign accept   = in_valid_i && in_ready_o;

  // Single-cycle op mux; shifts here are only used when they finish in one cycle
  always_comb begin
    alu_result = '0;
    alu_branch = 1'b0;
    case (alu_op_i)
      OP_ADD: alu_result = a_i + b_i;
      OP_SUB: alu_result = a_i - b_i;
      OP_AND: alu_result = a_i & b_i;
      OP_OR:  alu_result = a_i | b_i;
      OP_XOR: alu_result = a_i ^ b_i;
`ifdef ALU_EXEC_FAST_SHIFT_EN
      OP_SLL: alu_result = a_i << shamt;
      OP_SRL: alu_result = a_i >> shamt;
`else
      // Reached only with shamt == 0; nonzero amounts go to the serial shifter
      OP_SLL: alu_result = a_i;
      OP_SRL: alu_result = a_i;
`endif
      OP_LUI: alu_result = b_i;
      OP_BEQ: begin
        alu_result = a_i - b_i;
        alu_branch = (a_i == b_i);
      end
      OP_BNE: begin
        alu_result = a_i - b_i;
        alu_branch = (a_i != b_i);
      end
      default: begin
        alu_result = '0;
        alu_branch = 1'b0;
      end
    endcase
  end

`ifdef ALU_EXEC_FAST_SHIFT_EN

  assign in_ready_o  = out_free;
  assign load_result = accept;
  assign next_result = alu_result;
  assign next_branch = alu_branch;

`else

  state_e                state_q;
  state_e                state_d;
  logic                  is_shift;
  logic                  start_shift;
  logic                  shift_done;
  logic [DATA_WIDTH-1:0] shift_data;

  assign is_shift    = (alu_op_i == OP_SLL) || (alu_op_i == OP_SRL);
  assign start_shift = accept && is_shift && (shamt != '0);
  assign in_ready_o  = (state_q == ST_IDLE) && out_free;

  // A finished shift and a new accept cannot coincide: input is stalled in SHIFT
  assign load_result = (accept && !start_shift) || shift_done;
  assign next_result = shift_done ? shift_data : alu_result;
  assign next_branch = shift_done ? 1'b0 : alu_branch;

  alu_serial_shifter #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SHAMT_WIDTH (SHAMT_WIDTH)
  ) u_shifter (
    .clk      (clk),
    .reset    (reset),
    .start    (start_shift),
    .dir      ((alu_op_i == OP_SRL) ? SHIFT_RIGHT : SHIFT_LEFT),
    .data_in  (a_i),
    .amount   (shamt),
    .done     (shift_done),
    .data_out (shift_data)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: enter SHIFT on a multi-cycle shift, leave when it completes
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_shift) state_d = ST_SHIFT;
      ST_SHIFT: if (shift_done)  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

`endif

  // Output register: load a new result, otherwise clear valid once drained
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      branch_q    <= 1'b0;
    end else if (load_result) begin
      out_valid_q <= 1'b1;
      result_q    <= next_result;
      zero_q      <= (next_result == '0);
      branch_q    <= next_branch;
    end else if (out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign zero_o      = zero_q;
  assign branch_o    = branch_q;

endmodule
